stream_xbar_switch: RTL and testbench
=====================================

STREAM_XBAR_SWITCH -- requirements
Module: stream_xbar_switch

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 8, meaning data bits per beat.
REQ-002 SHALL have parameter S_DATA_COUNT, default 2, meaning number of input (slave) streams, >=2.
REQ-003 SHALL have parameter M_DATA_COUNT, default 3, meaning number of output (master) streams, >=2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning entries per output FIFO, power of 2, >=2.
REQ-005 SHALL have localparams T_ID___WIDTH = $clog2(S_DATA_COUNT), T_DEST_WIDTH = $clog2(M_DATA_COUNT), CNT_WIDTH = 16.
REQ-006 SHALL have port clk_i, input, 1, sole clock; all state on its rising edge.
REQ-007 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port s_data_i, input, T_DATA_WIDTH x S_DATA_COUNT, input beat data.
REQ-009 SHALL have port s_dest_i, input, T_DEST_WIDTH x S_DATA_COUNT, target master index.
REQ-010 SHALL have ports s_last_i, s_valid_i, input, S_DATA_COUNT, and s_ready_o, output, S_DATA_COUNT: packet end, valid, ready per source.
REQ-011 SHALL have ports m_data_o (T_DATA_WIDTH x M_DATA_COUNT) and m_id_o (T_ID___WIDTH x M_DATA_COUNT), outputs: beat data and originating source index.
REQ-012 SHALL have ports m_last_o, m_valid_o, outputs, M_DATA_COUNT, and m_ready_i, input, M_DATA_COUNT.
REQ-013 SHALL have port drop_cnt_o, output, CNT_WIDTH, count of beats dropped for invalid destination.

Function
REQ-014 SHALL transfer a beat on source j only when s_valid_i[j] && s_ready_o[j]; on master i only when m_valid_o[i] && m_ready_i[i].
REQ-015 SHALL run one arbiter per master i with states IDLE and LOCKED(owner).
REQ-016 SHALL treat source j as requesting master i in IDLE when s_valid_i[j], s_dest_i[j]==i, and j owns no lock on any master.
REQ-017 SHALL, in IDLE with FIFO i not full, grant the same cycle to the first requester searching round-robin from rr_ptr[i]+1 upward with wrap.
REQ-018 SHALL move IDLE->LOCKED(j) when granted beat is accepted with s_last_i[j]=0; a single-beat packet (last=1) leaves arbiter in IDLE.
REQ-019 SHALL, in LOCKED(j), route only source j to master i regardless of s_dest_i[j]; all other requesters stall.
REQ-020 SHALL move LOCKED(j)->IDLE when source j's beat with s_last_i[j]=1 is accepted.
REQ-021 SHALL load rr_ptr[i] with j on every accepted beat having s_last_i=1.
REQ-022 SHALL drive s_ready_o[j]=1 when j is granted/owner of master i and FIFO i is not full; otherwise 0 except REQ-023.
REQ-023 SHALL, for unlocked source j with s_dest_i[j]>=M_DATA_COUNT, assert s_ready_o[j]=1, discard the beat, increment drop_cnt_o, saturating at all-ones.
REQ-024 SHALL push {data, id=j, last} into FIFO i on accept; m_*_o[i] present FIFO head; m_valid_o[i] = FIFO not empty.
REQ-025 SHALL give one-cycle latency: beat accepted at edge N is visible on m_*_o from N+1.
REQ-026 SHALL support simultaneous push and pop on a non-full FIFO, count unchanged; when full, push is refused even if a pop occurs that cycle.
REQ-027 SHALL use read/write pointers of $clog2(FIFO_DEPTH)+1 bits wrapping modulo 2*FIFO_DEPTH; full when MSBs differ and remainder equal.
REQ-028 SHALL keep m_data_o/m_id_o/m_last_o stable while m_valid_o high and m_ready_i low.

Reset
REQ-029 SHALL, on rst_in low, immediately empty all FIFOs, set all arbiters IDLE, rr_ptr to S_DATA_COUNT-1 (source 0 first), drop_cnt_o to 0.
REQ-030 SHALL drive m_valid_o=0 and s_ready_o=0 while rst_in low; m_data_o/m_id_o/m_last_o are 0; partial packets are lost.

Structure
REQ-031 SHALL place arbiter state enum, CNT_WIDTH and FIFO entry struct in package stream_xbar_pkg.
REQ-032 SHALL instantiate sub-module stream_xbar_rr_arb once per master (round-robin pick plus lock state).

Verification
REQ-033 Src0 and src1 send 1-beat packets to master 1 every cycle, m_ready_i=all-ones -> m_id_o[1] alternates 0,1,0,1 from cycle after reset release.
REQ-034 Src0 sends 3-beat packet to master 2 while src1 requests master 2 -> src1 stalls until src0 last beat accepted; master 2 outputs ids 0,0,0,1.
REQ-035 FIFO_DEPTH=4, m_ready_i[0]=0, src0 streams to master 0 -> exactly 4 accepted, s_ready_o[0]=0 thereafter; m_ready_i[0]=1 drains data in order.
REQ-036 M_DATA_COUNT=3, src1 s_dest_i=3 for 5 beats -> s_ready_o[1]=1, no m_valid_o, drop_cnt_o=5.
REQ-037 rst_in low mid-packet with FIFO 2 holding 2 entries -> m_valid_o=0 same cycle, arbiters IDLE; new packet after release is accepted normally.
REQ-038 Src0 and src1 stream to masters 0 and 2 concurrently -> both sustain one beat per cycle, no cross-routing.

Source files
------------

// File: rtl/stream_xbar_pkg.sv
// stream_xbar_pkg: shared types and constants for the stream crossbar switch
// Provides the per-master arbiter state, the drop counter width and the output FIFO entry layout.
package stream_xbar_pkg;
  localparam int CNT_WIDTH = 16;
  localparam int ENTRY_DATA_MAX = 64;
  localparam int ENTRY_ID_MAX = 8;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  // Fixed-width entry; the switch uses the low T_DATA_WIDTH / T_ID___WIDTH bits.
  typedef struct packed {
    logic [ENTRY_DATA_MAX-1:0] data;
    logic [ENTRY_ID_MAX-1:0]   id;
    logic                      last;
  } fifo_entry_t;
endpackage

// File: rtl/stream_xbar_switch_if.sv
// stream_xbar_if: source-side and master-side stream bundle of the crossbar
// s_*: per-source data/dest/last/valid in, ready out; m_*: per-master data/id/last/valid out, ready in;
// drop_cnt_o: beats discarded for an out-of-range destination.
interface stream_xbar_if import stream_xbar_pkg::*; #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3
);
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT);
  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i;
  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
  logic [S_DATA_COUNT-1:0]                   s_last_i;
  logic [S_DATA_COUNT-1:0]                   s_valid_i;
  logic [S_DATA_COUNT-1:0]                   s_ready_o;
  logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o;
  logic [M_DATA_COUNT-1:0]                   m_last_o;
  logic [M_DATA_COUNT-1:0]                   m_valid_o;
  logic [M_DATA_COUNT-1:0]                   m_ready_i;
  logic [CNT_WIDTH-1:0]                      drop_cnt_o;
  modport slave (
    input  s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o, drop_cnt_o
  );
  modport master (
    output s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o, drop_cnt_o
  );
endinterface

// File: rtl/stream_xbar_rr_arb.sv
// stream_xbar_rr_arb: round-robin pick plus packet lock for one output master
// req: idle-state requests; valid/last: source handshake; full: target FIFO full;
// sel: source allowed to transfer; own: lock owner one-hot; push/src: accepted beat and its source.
module stream_xbar_rr_arb import stream_xbar_pkg::*; #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  valid,
  input  logic [N-1:0]  last,
  input  logic          full,
  output logic [N-1:0]  sel,
  output logic [N-1:0]  own,
  output logic          push,
  output logic [IW-1:0] src
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick, idx;
  logic pick_v;
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(N-1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  always_comb begin
    pick_v = 1'b0;
    pick = '0;
    idx = '0;
    // Scan downward so the nearest requester after ptr_q wins.
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % N);
      if (req[idx]) begin
        pick_v = 1'b1;
        pick = idx;
      end
    end
    src = (state_q == ARB_LOCKED) ? owner_q : pick;
    sel = ((state_q == ARB_LOCKED || pick_v) && !full) ? N'(1) << src : '0;
    push = |(sel & valid);
    state_d = push ? (last[src] ? ARB_IDLE : ARB_LOCKED) : state_q;
    owner_d = push ? src : owner_q;
    ptr_d = (push && last[src]) ? src : ptr_q;
  end
  assign own = (state_q == ARB_LOCKED) ? N'(1) << owner_q : '0;
endmodule

// File: rtl/stream_xbar_switch.sv
// stream_xbar_switch: packet-locked round-robin crossbar with per-master output FIFOs
// clk_i: clock; rst_in: async active-low reset; bus: source/master stream bundle (slave view).
module stream_xbar_switch import stream_xbar_pkg::*; #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input logic         clk_i,
  input logic         rst_in,
  stream_xbar_if.slave bus
);
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req, sel, own;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] src;
  logic [M_DATA_COUNT-1:0] push, full;
  logic [S_DATA_COUNT-1:0] busy, drop, rdy;
  logic [CNT_WIDTH-1:0] drop_cnt_q;
  logic [CNT_WIDTH:0] ndrop, dsum;
  always_comb begin
    busy = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) busy = busy | own[i];
  end
  // A source holding a lock is invisible to every other arbiter and to the drop path.
  always_comb begin
    req = '0;
    for (int i = 0; i < M_DATA_COUNT; i++)
      for (int j = 0; j < S_DATA_COUNT; j++)
        req[i][j] = bus.s_valid_i[j] && !busy[j] && bus.s_dest_i[j] == T_DEST_WIDTH'(i);
  end
  always_comb begin
    drop = '0;
    ndrop = '0;
    for (int j = 0; j < S_DATA_COUNT; j++) begin
      drop[j] = !busy[j] && int'(bus.s_dest_i[j]) >= M_DATA_COUNT;
      ndrop = ndrop + (CNT_WIDTH+1)'(drop[j] && bus.s_valid_i[j]);
    end
    dsum = {1'b0, drop_cnt_q} + ndrop;
    rdy = drop;
    for (int i = 0; i < M_DATA_COUNT; i++) rdy = rdy | sel[i];
  end
  assign bus.s_ready_o = rst_in ? rdy : '0;
  assign bus.drop_cnt_o = drop_cnt_q;
  always_ff @(posedge clk_i or negedge rst_in)
    if (!rst_in) drop_cnt_q <= '0;
    else drop_cnt_q <= dsum[CNT_WIDTH] ? '1 : dsum[CNT_WIDTH-1:0];
  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_m
    fifo_entry_t mem [FIFO_DEPTH];
    fifo_entry_t head;
    logic [AW:0] wr_q, rd_q;
    logic empty, pop, unused_hi;
    stream_xbar_rr_arb #(.N(S_DATA_COUNT)) u_arb (
      .clk_i (clk_i),
      .rst_in(rst_in),
      .req   (req[i]),
      .valid (bus.s_valid_i),
      .last  (bus.s_last_i),
      .full  (full[i]),
      .sel   (sel[i]),
      .own   (own[i]),
      .push  (push[i]),
      .src   (src[i])
    );
    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = wr_q == rd_q;
    assign full[i] = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop = !empty && bus.m_ready_i[i];
    assign head = empty ? '0 : mem[rd_q[AW-1:0]];
    always_ff @(posedge clk_i or negedge rst_in)
      if (!rst_in) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push[i]) wr_q <= wr_q + (AW+1)'(1);
        if (pop) rd_q <= rd_q + (AW+1)'(1);
      end
    always_ff @(posedge clk_i)
      if (push[i]) mem[wr_q[AW-1:0]] <= '{data: ENTRY_DATA_MAX'(bus.s_data_i[src[i]]),
                                          id: ENTRY_ID_MAX'(src[i]),
                                          last: bus.s_last_i[src[i]]};
    assign bus.m_data_o[i] = head.data[T_DATA_WIDTH-1:0];
    assign bus.m_id_o[i] = head.id[T_ID___WIDTH-1:0];
    assign bus.m_last_o[i] = head.last;
    assign bus.m_valid_o[i] = !empty;
    // Entry bits above the configured widths are always zero.
    assign unused_hi = ^{head.data >> T_DATA_WIDTH, head.id >> T_ID___WIDTH};
  end
endmodule

// File: tb/tb_stream_xbar_switch.sv
// tb_stream_xbar_switch: directed self-checking bench for stream_xbar_switch
module tb_stream_xbar_switch;
  localparam int TW = 8;
  localparam int S = 2;
  localparam int M = 3;
  localparam int FD = 4;
  logic clk_i = 1'b0;
  logic rst_in = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk_i = ~clk_i;
  stream_xbar_if #(.T_DATA_WIDTH(TW), .S_DATA_COUNT(S), .M_DATA_COUNT(M)) bus ();
  stream_xbar_switch #(.T_DATA_WIDTH(TW), .S_DATA_COUNT(S), .M_DATA_COUNT(M), .FIFO_DEPTH(FD)) dut (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic drive(input int j, input logic v, input logic [1:0] d, input logic l, input logic [7:0] dat);
    bus.s_valid_i[j] = v;
    bus.s_dest_i[j] = d;
    bus.s_last_i[j] = l;
    bus.s_data_i[j] = dat;
  endtask
  initial begin
    bus.s_valid_i = '0;
    bus.s_last_i = '0;
    bus.s_dest_i = '0;
    bus.s_data_i = '0;
    bus.m_ready_i = '1;
    repeat (2) @(posedge clk_i);
    #2;
    drive(0, 1, 2'd1, 1, 8'h11);
    drive(1, 1, 2'd3, 1, 8'h22);
    settle();
    chk("rst_m_valid", 32'(bus.m_valid_o), 0);
    chk("rst_s_ready", 32'(bus.s_ready_o), 0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt_o), 0);
    chk("rst_m_data", 32'(bus.m_data_o), 0);
    tick();
    chk("rst_hold_m_valid", 32'(bus.m_valid_o), 0);
    chk("rst_hold_drop_cnt", 32'(bus.drop_cnt_o), 0);
    drive(0, 0, 2'd0, 0, 8'h00);
    drive(1, 0, 2'd0, 0, 8'h00);
    rst_in = 1'b1;
    // Two single-beat sources contending for master 1 alternate.
    drive(0, 1, 2'd1, 1, 8'h10);
    drive(1, 1, 2'd1, 1, 8'h21);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_s_ready", 32'(bus.s_ready_o), (k % 2 == 0) ? 1 : 2);
      tick();
      chk("rr_m_id1", 32'(bus.m_id_o[1]), k % 2);
      chk("rr_m_data1", 32'(bus.m_data_o[1]), (k % 2 == 0) ? 32'h10 : 32'h21);
      chk("rr_m_valid", 32'(bus.m_valid_o), 3'b010);
    end
    drive(0, 0, 2'd0, 0, 8'h00);
    drive(1, 0, 2'd0, 0, 8'h00);
    tick();
    chk("rr_drained", 32'(bus.m_valid_o), 0);
    // Source 0 locks master 2 for a 3-beat packet; source 1 waits.
    drive(0, 1, 2'd2, 0, 8'h30);
    drive(1, 1, 2'd2, 1, 8'h40);
    settle();
    chk("lock_b0_ready", 32'(bus.s_ready_o), 1);
    tick();
    chk("lock_b0_id", 32'(bus.m_id_o[2]), 0);
    chk("lock_b0_data", 32'(bus.m_data_o[2]), 32'h30);
    chk("lock_b0_last", 32'(bus.m_last_o[2]), 0);
    drive(0, 1, 2'd2, 0, 8'h31);
    settle();
    chk("lock_b1_ready", 32'(bus.s_ready_o), 1);
    tick();
    chk("lock_b1_data", 32'(bus.m_data_o[2]), 32'h31);
    chk("lock_b1_id", 32'(bus.m_id_o[2]), 0);
    drive(0, 1, 2'd2, 1, 8'h32);
    settle();
    chk("lock_b2_ready", 32'(bus.s_ready_o), 1);
    tick();
    chk("lock_b2_data", 32'(bus.m_data_o[2]), 32'h32);
    chk("lock_b2_last", 32'(bus.m_last_o[2]), 1);
    drive(0, 0, 2'd0, 0, 8'h00);
    settle();
    chk("lock_src1_ready", 32'(bus.s_ready_o), 2);
    tick();
    chk("lock_src1_id", 32'(bus.m_id_o[2]), 1);
    chk("lock_src1_data", 32'(bus.m_data_o[2]), 32'h40);
    drive(1, 0, 2'd0, 0, 8'h00);
    tick();
    chk("lock_drained", 32'(bus.m_valid_o), 0);
    // Master 0 stalled: exactly FIFO_DEPTH beats are accepted.
    bus.m_ready_i = 3'b110;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 2'd0, 1, 8'(8'h50 + k));
      settle();
      chk("full_s_ready0", 32'(bus.s_ready_o[0]), (k < FD) ? 1 : 0);
      tick();
      chk("full_head_hold", 32'(bus.m_data_o[0]), 32'h50);
    end
    bus.m_ready_i = '1;
    drive(0, 1, 2'd0, 1, 8'h60);
    settle();
    chk("full_pop_no_push", 32'(bus.s_ready_o[0]), 0);
    tick();
    drive(0, 0, 2'd0, 0, 8'h00);
    for (int k = 1; k < 4; k++) begin
      chk("full_drain_data", 32'(bus.m_data_o[0]), 32'h50 + k);
      tick();
    end
    chk("full_drained", 32'(bus.m_valid_o), 0);
    // Out-of-range destination is accepted and discarded.
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 2'd3, 1, 8'h5a);
      settle();
      chk("drop_s_ready1", 32'(bus.s_ready_o[1]), 1);
      tick();
      chk("drop_m_valid", 32'(bus.m_valid_o), 0);
    end
    chk("drop_cnt", 32'(bus.drop_cnt_o), 5);
    drive(1, 0, 2'd0, 0, 8'h00);
    // Reset mid-packet with two beats queued on master 2.
    bus.m_ready_i = 3'b011;
    drive(0, 1, 2'd2, 0, 8'h70);
    tick();
    drive(0, 1, 2'd2, 0, 8'h71);
    tick();
    chk("midrst_m_valid2", 32'(bus.m_valid_o[2]), 1);
    rst_in = 1'b0;
    settle();
    chk("midrst_m_valid", 32'(bus.m_valid_o), 0);
    chk("midrst_s_ready", 32'(bus.s_ready_o), 0);
    chk("midrst_drop_cnt", 32'(bus.drop_cnt_o), 0);
    tick();
    rst_in = 1'b1;
    drive(0, 0, 2'd0, 0, 8'h00);
    drive(1, 1, 2'd2, 1, 8'h80);
    settle();
    chk("postrst_ready", 32'(bus.s_ready_o), 2);
    tick();
    chk("postrst_m_valid", 32'(bus.m_valid_o), 3'b100);
    chk("postrst_id", 32'(bus.m_id_o[2]), 1);
    chk("postrst_data", 32'(bus.m_data_o[2]), 32'h80);
    drive(1, 0, 2'd0, 0, 8'h00);
    bus.m_ready_i = '1;
    tick();
    // Two independent streams run at full rate.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 2'd0, k == 3, 8'(8'h90 + k));
      drive(1, 1, 2'd2, k == 3, 8'(8'ha0 + k));
      settle();
      chk("par_s_ready", 32'(bus.s_ready_o), 3);
      tick();
      chk("par_m_valid", 32'(bus.m_valid_o), 3'b101);
      chk("par_data0", 32'(bus.m_data_o[0]), 32'h90 + k);
      chk("par_id0", 32'(bus.m_id_o[0]), 0);
      chk("par_data2", 32'(bus.m_data_o[2]), 32'ha0 + k);
      chk("par_id2", 32'(bus.m_id_o[2]), 1);
    end
    drive(0, 0, 2'd0, 0, 8'h00);
    drive(1, 0, 2'd0, 0, 8'h00);
    tick();
    chk("par_drained", 32'(bus.m_valid_o), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
